// File: rtl/video_rx_monitor.sv
// -----------------------------------------------------------------------------
// video_rx_monitor
//
// Receive-side monitor for a DE/HS/VS/RGB pixel stream. Measures line and
// frame timing, computes a CRC-16-CCITT over the "lit pixel" bitstream of each
// frame and reports whether the timing of the last two frames matched.
//
// Ports
//   I_pxl_clk    pixel clock (only clock)
//   I_rst        asynchronous active-high reset
//   I_de         data enable
//   I_hs, I_vs   horizontal / vertical sync, active level SYNC_POL
//   I_data_r/g/b 8-bit colour components
//   O_h_total    clocks per line (last line of the frame)
//   O_h_sync     HS-active clocks in that line
//   O_h_active   DE clocks in the last line of the frame that had any DE
//   O_v_total    lines per frame
//   O_v_sync     lines started while VS was active
//   O_v_active   lines containing at least one DE clock
//   O_crc        CRC-16-CCITT (poly 0x1021, MSB first) of lit-pixel bits
//   O_frame_cnt  number of completed measured frames (wraps)
//   O_valid      one-cycle pulse when the results above update
//   O_locked     timing of the last two updates was identical
//
// Frame FSM
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   ST_SYNC | after reset; waiting for the first VS edge, no results yet
//   ST_MEAS | accumulating a frame; a VS edge snapshots it
//   ST_UPD  | snapshot is copied to the outputs, O_valid pulses
// -----------------------------------------------------------------------------
module video_rx_monitor #(
    parameter logic        SYNC_POL = 1'b1,
    parameter int unsigned CNT_W    = 12,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst,
    input  logic             I_de,
    input  logic             I_hs,
    input  logic             I_vs,
    input  logic [7:0]       I_data_r,
    input  logic [7:0]       I_data_g,
    input  logic [7:0]       I_data_b,
    output logic [CNT_W-1:0] O_h_total,
    output logic [CNT_W-1:0] O_h_sync,
    output logic [CNT_W-1:0] O_h_active,
    output logic [CNT_W-1:0] O_v_total,
    output logic [CNT_W-1:0] O_v_sync,
    output logic [CNT_W-1:0] O_v_active,
    output logic [15:0]      O_crc,
    output logic [15:0]      O_frame_cnt,
    output logic             O_valid,
    output logic             O_locked
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_MEAS = 2'd1,
        ST_UPD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]      CRC_POLY = 16'h1021;

    // Counters stick at all-ones so a missing sync shows up as "max",
    // never as a small wrapped value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        logic [15:0] nxt;
        nxt = {crc[14:0], 1'b0};
        if (crc[15] ^ din) begin
            nxt = nxt ^ CRC_POLY;
        end
        return nxt;
    endfunction

    // ---------------------------------------------------------------------
    // Input sampling: s1 is the registered pin value, s2 the previous s1.
    // ---------------------------------------------------------------------
    logic        hs_s1_q, vs_s1_q, de_s1_q;
    logic        hs_s2_q, vs_s2_q;
    logic [23:0] rgb_s1_q;

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            hs_s1_q  <= ~SYNC_POL;
            vs_s1_q  <= ~SYNC_POL;
            hs_s2_q  <= ~SYNC_POL;
            vs_s2_q  <= ~SYNC_POL;
            de_s1_q  <= 1'b0;
            rgb_s1_q <= '0;
        end else begin
            hs_s1_q  <= I_hs;
            vs_s1_q  <= I_vs;
            hs_s2_q  <= hs_s1_q;
            vs_s2_q  <= vs_s1_q;
            de_s1_q  <= I_de;
            rgb_s1_q <= {I_data_r, I_data_g, I_data_b};
        end
    end

    logic hs_act, vs_act, hs_act_prev, vs_act_prev;
    logic hs_edge, vs_edge, pix_lit;

    assign hs_act      = (hs_s1_q == SYNC_POL);
    assign vs_act      = (vs_s1_q == SYNC_POL);
    assign hs_act_prev = (hs_s2_q == SYNC_POL);
    assign vs_act_prev = (vs_s2_q == SYNC_POL);
    assign hs_edge     = hs_act & ~hs_act_prev;
    assign vs_edge     = vs_act & ~vs_act_prev;
    assign pix_lit     = |rgb_s1_q;

    // ---------------------------------------------------------------------
    // Line / frame accumulators
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hs_w_q, hs_w_d;
    logic [CNT_W-1:0] de_w_q, de_w_d;
    logic [CNT_W-1:0] line_total_q, line_total_d;
    logic [CNT_W-1:0] line_sync_q, line_sync_d;
    logic [CNT_W-1:0] last_active_q, last_active_d;
    logic [CNT_W-1:0] vtot_q, vtot_d;
    logic [CNT_W-1:0] vsync_q, vsync_d;
    logic [CNT_W-1:0] vact_q, vact_d;
    logic [15:0]      crc_q, crc_d;

    // Frame values including the line closed in this cycle; these are what
    // the ending frame reports when a VS edge coincides with an HS edge.
    logic [CNT_W-1:0] last_active_cl, vtot_cl, vsync_cl, vact_cl;
    logic [15:0]      crc_cl;

    // Snapshot of the ending frame, held until the update cycle.
    logic [CNT_W-1:0] snap_h_total_q, snap_h_total_d;
    logic [CNT_W-1:0] snap_h_sync_q, snap_h_sync_d;
    logic [CNT_W-1:0] snap_h_active_q, snap_h_active_d;
    logic [CNT_W-1:0] snap_v_total_q, snap_v_total_d;
    logic [CNT_W-1:0] snap_v_sync_q, snap_v_sync_d;
    logic [CNT_W-1:0] snap_v_active_q, snap_v_active_d;
    logic [15:0]      snap_crc_q, snap_crc_d;

    always_comb begin
        hcnt_d = hs_edge ? CNT_ONE : sat_inc(hcnt_q);

        hs_w_d = hs_w_q;
        if (hs_edge) begin
            hs_w_d = CNT_ONE;
        end else if (hs_act) begin
            hs_w_d = sat_inc(hs_w_q);
        end

        de_w_d = de_w_q;
        if (hs_edge) begin
            de_w_d = CNT_ZERO;
        end else if (de_s1_q) begin
            de_w_d = sat_inc(de_w_q);
        end

        line_total_d   = line_total_q;
        line_sync_d    = line_sync_q;
        last_active_cl = last_active_q;
        vtot_cl        = vtot_q;
        vsync_cl       = vsync_q;
        vact_cl        = vact_q;
        if (hs_edge) begin
            line_total_d = hcnt_q;
            line_sync_d  = hs_w_q;
            if (de_w_q != CNT_ZERO) begin
                last_active_cl = de_w_q;
                vact_cl        = sat_inc(vact_q);
            end
            vtot_cl = sat_inc(vtot_q);
            if (vs_act) begin
                vsync_cl = sat_inc(vsync_q);
            end
        end

        crc_cl = de_s1_q ? crc_step(crc_q, pix_lit) : crc_q;

        if (vs_edge) begin
            last_active_d = CNT_ZERO;
            vtot_d        = CNT_ZERO;
            vsync_d       = CNT_ZERO;
            vact_d        = CNT_ZERO;
            crc_d         = CRC_INIT;
        end else begin
            last_active_d = last_active_cl;
            vtot_d        = vtot_cl;
            vsync_d       = vsync_cl;
            vact_d        = vact_cl;
            crc_d         = crc_cl;
        end

        snap_h_total_d  = snap_h_total_q;
        snap_h_sync_d   = snap_h_sync_q;
        snap_h_active_d = snap_h_active_q;
        snap_v_total_d  = snap_v_total_q;
        snap_v_sync_d   = snap_v_sync_q;
        snap_v_active_d = snap_v_active_q;
        snap_crc_d      = snap_crc_q;
        if (vs_edge) begin
            snap_h_total_d  = line_total_d;
            snap_h_sync_d   = line_sync_d;
            snap_h_active_d = last_active_cl;
            snap_v_total_d  = vtot_cl;
            snap_v_sync_d   = vsync_cl;
            snap_v_active_d = vact_cl;
            snap_crc_d      = crc_cl;
        end
    end

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            hcnt_q          <= CNT_ZERO;
            hs_w_q          <= CNT_ZERO;
            de_w_q          <= CNT_ZERO;
            line_total_q    <= CNT_ZERO;
            line_sync_q     <= CNT_ZERO;
            last_active_q   <= CNT_ZERO;
            vtot_q          <= CNT_ZERO;
            vsync_q         <= CNT_ZERO;
            vact_q          <= CNT_ZERO;
            crc_q           <= CRC_INIT;
            snap_h_total_q  <= CNT_ZERO;
            snap_h_sync_q   <= CNT_ZERO;
            snap_h_active_q <= CNT_ZERO;
            snap_v_total_q  <= CNT_ZERO;
            snap_v_sync_q   <= CNT_ZERO;
            snap_v_active_q <= CNT_ZERO;
            snap_crc_q      <= 16'h0000;
        end else begin
            hcnt_q          <= hcnt_d;
            hs_w_q          <= hs_w_d;
            de_w_q          <= de_w_d;
            line_total_q    <= line_total_d;
            line_sync_q     <= line_sync_d;
            last_active_q   <= last_active_d;
            vtot_q          <= vtot_d;
            vsync_q         <= vsync_d;
            vact_q          <= vact_d;
            crc_q           <= crc_d;
            snap_h_total_q  <= snap_h_total_d;
            snap_h_sync_q   <= snap_h_sync_d;
            snap_h_active_q <= snap_h_active_d;
            snap_v_total_q  <= snap_v_total_d;
            snap_v_sync_q   <= snap_v_sync_d;
            snap_v_active_q <= snap_v_active_d;
            snap_crc_q      <= snap_crc_d;
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    state_t state_q, state_d;
    logic   upd;

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        upd     = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (vs_edge) begin
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (vs_edge) begin
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                upd     = 1'b1;
                // A back-to-back VS edge has already refreshed the snapshot.
                state_d = vs_edge ? ST_UPD : ST_MEAS;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Result registers and lock tracking
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] h_total_q, h_sync_q, h_active_q;
    logic [CNT_W-1:0] v_total_q, v_sync_q, v_active_q;
    logic [15:0]      crc_out_q, frame_cnt_q;
    logic             valid_q, locked_q, locked_d;
    logic             have_prev_q;
    logic             timing_match;

    // The current outputs still hold the previous update's timing set.
    assign timing_match = ({snap_h_total_q, snap_h_sync_q, snap_h_active_q,
                            snap_v_total_q, snap_v_sync_q, snap_v_active_q} ==
                           {h_total_q, h_sync_q, h_active_q,
                            v_total_q, v_sync_q, v_active_q});
    assign locked_d     = have_prev_q & timing_match;

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            h_total_q   <= CNT_ZERO;
            h_sync_q    <= CNT_ZERO;
            h_active_q  <= CNT_ZERO;
            v_total_q   <= CNT_ZERO;
            v_sync_q    <= CNT_ZERO;
            v_active_q  <= CNT_ZERO;
            crc_out_q   <= 16'h0000;
            frame_cnt_q <= 16'h0000;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            valid_q <= upd;
            if (upd) begin
                h_total_q   <= snap_h_total_q;
                h_sync_q    <= snap_h_sync_q;
                h_active_q  <= snap_h_active_q;
                v_total_q   <= snap_v_total_q;
                v_sync_q    <= snap_v_sync_q;
                v_active_q  <= snap_v_active_q;
                crc_out_q   <= snap_crc_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                locked_q    <= locked_d;
                have_prev_q <= 1'b1;
            end
        end
    end

    assign O_h_total   = h_total_q;
    assign O_h_sync    = h_sync_q;
    assign O_h_active  = h_active_q;
    assign O_v_total   = v_total_q;
    assign O_v_sync    = v_sync_q;
    assign O_v_active  = v_active_q;
    assign O_crc       = crc_out_q;
    assign O_frame_cnt = frame_cnt_q;
    assign O_valid     = valid_q;
    assign O_locked    = locked_q;

endmodule

// File: tb/tb_video_rx_monitor.sv
`timescale 1ns/1ps
module tb_video_rx_monitor;

    localparam int CNT_W      = 12;
    localparam int H_TOT      = 40;
    localparam int H_SYNC     = 6;
    localparam int H_BP       = 6;
    localparam int H_ACT      = 24;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 2;
    localparam int V_ACT      = 6;
    localparam int NF         = 11;
    localparam int LONG_EXTRA = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, hs, vs, de;
    logic [7:0] dr, dg, db;
    logic       hs_n, vs_n;
    assign hs_n = ~hs;
    assign vs_n = ~vs;

    logic [CNT_W-1:0] p_ht, p_hs, p_ha, p_vt, p_vs, p_va;
    logic [15:0]      p_crc, p_fc;
    logic             p_valid, p_lock;
    logic [CNT_W-1:0] n_ht, n_hs, n_ha, n_vt, n_vs, n_va;
    logic [15:0]      n_crc, n_fc;
    logic             n_valid, n_lock;

    video_rx_monitor #(.SYNC_POL(1'b1), .CNT_W(CNT_W), .CRC_INIT(16'hFFFF)) u_pos (
        .I_pxl_clk(clk), .I_rst(rst), .I_de(de), .I_hs(hs), .I_vs(vs),
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
        .O_h_total(p_ht), .O_h_sync(p_hs), .O_h_active(p_ha),
        .O_v_total(p_vt), .O_v_sync(p_vs), .O_v_active(p_va),
        .O_crc(p_crc), .O_frame_cnt(p_fc), .O_valid(p_valid), .O_locked(p_lock)
    );

    video_rx_monitor #(.SYNC_POL(1'b0), .CNT_W(CNT_W), .CRC_INIT(16'hFFFF)) u_neg (
        .I_pxl_clk(clk), .I_rst(rst), .I_de(de), .I_hs(hs_n), .I_vs(vs_n),
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
        .O_h_total(n_ht), .O_h_sync(n_hs), .O_h_active(n_ha),
        .O_v_total(n_vt), .O_v_sync(n_vs), .O_v_active(n_va),
        .O_crc(n_crc), .O_frame_cnt(n_fc), .O_valid(n_valid), .O_locked(n_lock)
    );

    typedef struct {
        int          vlines;
        int          pix_idx;
        logic [23:0] pix_val;
        bit          long_last;
        bit          rst_mid;
        bit          exp_valid;
        int          exp_htot;
        int          exp_vtot;
        bit          exp_lock;
    } frame_t;

    typedef struct {
        int          ht, hs, ha, vt, vs, va;
        logic [15:0] crc;
        logic [15:0] fc;
        bit          lock;
        int          cyc;
    } exp_t;

    frame_t      tbl [NF];
    exp_t        q_pos [$];
    exp_t        q_neg [$];
    exp_t        e_pos, e_neg;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] crc_m, golden_black, fc_exp;
    logic [15:0] obs_crc [16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (c[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    function automatic logic [15:0] crc_zeros(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = crc_bit(c, 1'b0);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cmp_upd(input string tag, input exp_t e,
                           input logic [CNT_W-1:0] ht, input logic [CNT_W-1:0] hsw,
                           input logic [CNT_W-1:0] ha, input logic [CNT_W-1:0] vt,
                           input logic [CNT_W-1:0] vsw, input logic [CNT_W-1:0] va,
                           input logic [15:0] crc, input logic [15:0] fc, input logic lock);
        chk({tag, "_h_total"},   32'(ht),  e.ht);
        chk({tag, "_h_sync"},    32'(hsw), e.hs);
        chk({tag, "_h_active"},  32'(ha),  e.ha);
        chk({tag, "_v_total"},   32'(vt),  e.vt);
        chk({tag, "_v_sync"},    32'(vsw), e.vs);
        chk({tag, "_v_active"},  32'(va),  e.va);
        chk({tag, "_crc"},       32'(crc), 32'(e.crc));
        chk({tag, "_frame_cnt"}, 32'(fc),  32'(e.fc));
        chk({tag, "_locked"},    32'(lock), 32'(e.lock));
        chk({tag, "_latency"},   cyc,      e.cyc);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pos_frame_cnt"}, 32'(p_fc), 0);
        chk({tag, "_pos_h_total"},   32'(p_ht), 0);
        chk({tag, "_pos_v_total"},   32'(p_vt), 0);
        chk({tag, "_pos_crc"},       32'(p_crc), 0);
        chk({tag, "_pos_flags"},     32'({p_valid, p_lock}), 0);
        chk({tag, "_neg_frame_cnt"}, 32'(n_fc), 0);
        chk({tag, "_neg_h_total"},   32'(n_ht), 0);
    endtask

    // Expected results for frame k are queued when the VS edge ending it is driven.
    task automatic push_exp(input int k);
        exp_t e;
        e.ht   = tbl[k].exp_htot;
        e.hs   = H_SYNC;
        e.ha   = H_ACT;
        e.vt   = tbl[k].exp_vtot;
        e.vs   = V_SYNC;
        e.va   = V_ACT;
        e.crc  = (tbl[k].pix_idx < 0) ? golden_black : crc_m;
        fc_exp = fc_exp + 16'd1;
        e.fc   = fc_exp;
        e.lock = tbl[k].exp_lock;
        e.cyc  = cyc + 3;
        q_pos.push_back(e);
        q_neg.push_back(e);
    endtask

    task automatic do_mid_reset();
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        fc_exp = 16'd0;
    endtask

    task automatic drive_frame(input int k);
        int          len;
        logic [23:0] pix;
        for (int ln = 0; ln < tbl[k].vlines; ln++) begin
            len = H_TOT;
            if (tbl[k].long_last && ln == tbl[k].vlines - 1) len = H_TOT + LONG_EXTRA;
            for (int px = 0; px < len; px++) begin
                @(negedge clk);
                hs  = (px < H_SYNC);
                vs  = (ln < V_SYNC);
                de  = (ln >= V_SYNC + V_BP) && (ln < V_SYNC + V_BP + V_ACT) &&
                      (px >= H_SYNC + H_BP) && (px < H_SYNC + H_BP + H_ACT);
                pix = (de && ln == V_SYNC + V_BP && (px - H_SYNC - H_BP) == tbl[k].pix_idx)
                      ? tbl[k].pix_val : 24'h000000;
                {dr, dg, db} = pix;
                if (ln == 0 && px == 0) begin
                    if (k > 0 && tbl[k-1].exp_valid) push_exp(k - 1);
                    crc_m = 16'hFFFF;
                end
                if (de) crc_m = crc_bit(crc_m, |pix);
                if (tbl[k].rst_mid && ln == 6 && px == 20) do_mid_reset();
            end
        end
    endtask

    initial begin : mon_pos
        forever begin
            @(negedge clk);
            if (p_valid === 1'b1) begin
                if (q_pos.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_pos frame_cnt=%0d required no update", p_fc);
                end else begin
                    e_pos = q_pos.pop_front();
                    cmp_upd("pos", e_pos, p_ht, p_hs, p_ha, p_vt, p_vs, p_va, p_crc, p_fc, p_lock);
                    obs_crc[p_fc[3:0]] = p_crc;
                end
            end
        end
    end

    initial begin : mon_neg
        forever begin
            @(negedge clk);
            if (n_valid === 1'b1) begin
                if (q_neg.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_neg frame_cnt=%0d required no update", n_fc);
                end else begin
                    e_neg = q_neg.pop_front();
                    cmp_upd("neg", e_neg, n_ht, n_hs, n_ha, n_vt, n_vs, n_va, n_crc, n_fc, n_lock);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        //          vlines pix  value          long  rst   valid htot  vtot lock
        tbl[0]  = '{12,   -1, 24'h000000,   1'b0, 1'b0, 1'b1, 40,   12,  1'b0};
        tbl[1]  = '{12,   -1, 24'h000000,   1'b0, 1'b0, 1'b1, 40,   12,  1'b1};
        tbl[2]  = '{12,    0, 24'hFFFFFF,   1'b0, 1'b0, 1'b1, 40,   12,  1'b1};
        tbl[3]  = '{12,    1, 24'hFFFFFF,   1'b0, 1'b0, 1'b1, 40,   12,  1'b1};
        tbl[4]  = '{11,   -1, 24'h000000,   1'b0, 1'b0, 1'b1, 40,   11,  1'b0};
        tbl[5]  = '{11,    5, 24'h010000,   1'b0, 1'b0, 1'b1, 40,   11,  1'b1};
        tbl[6]  = '{12,   -1, 24'h000000,   1'b1, 1'b0, 1'b1, 4095, 12,  1'b0};
        tbl[7]  = '{12,   -1, 24'h000000,   1'b0, 1'b0, 1'b1, 40,   12,  1'b0};
        tbl[8]  = '{12,   -1, 24'h000000,   1'b0, 1'b1, 1'b0, 40,   12,  1'b0};
        tbl[9]  = '{12,   -1, 24'h000000,   1'b0, 1'b0, 1'b1, 40,   12,  1'b0};
        tbl[10] = '{3,    -1, 24'h000000,   1'b0, 1'b0, 1'b0, 40,   3,   1'b0};

        for (int i = 0; i < 16; i++) obs_crc[i] = 16'h0000;
        golden_black = crc_zeros(H_ACT * V_ACT);
        crc_m  = 16'hFFFF;
        fc_exp = 16'd0;
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        de  = 1'b0;
        {dr, dg, db} = 24'h000000;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_state");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < NF; k++) drive_frame(k);
        repeat (10) @(negedge clk);

        chk("missing_updates_pos", 32'(q_pos.size()), 0);
        chk("missing_updates_neg", 32'(q_neg.size()), 0);

        checks++;
        if (obs_crc[3] === golden_black) begin
            errors++;
            $display("FAIL white_pixel_crc actual=%h required not equal to black %h", obs_crc[3], golden_black);
        end
        checks++;
        if (obs_crc[4] === obs_crc[3]) begin
            errors++;
            $display("FAIL moved_pixel_crc actual=%h required not equal to %h", obs_crc[4], obs_crc[3]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_rx_monitor.md
Name: video_rx_monitor

Overview:
- Receive-side monitor for the pixel stream produced by the display timing/CRTC generator.
- Samples DE/HS/VS/RGB on the pixel clock and measures line and frame timing.
- Computes a per-frame CRC of lit pixels and tracks timing lock.
- Used on-chip for self-check/debug readback, and in benches as the scoreboard end of the video interface.

Parameters:
SYNC_POL, 1, active level of I_hs/I_vs (1 = sync pulse is high, matching the generator's O_hs/O_vs)
CNT_W, 12, width of all timing counters/results
CRC_INIT, 16'hFFFF, CRC-16-CCITT seed loaded at each frame start

Ports:
I_pxl_clk  in  1  pixel clock; only clock
I_rst  in  1  asynchronous, active-high reset
I_de  in  1  data enable
I_hs  in  1  horizontal sync, polarity SYNC_POL
I_vs  in  1  vertical sync, polarity SYNC_POL
I_data_r  in  8  red
I_data_g  in  8  green
I_data_b  in  8  blue
O_h_total  out  CNT_W  clocks per line
O_h_sync  out  CNT_W  clocks HS active per line
O_h_active  out  CNT_W  DE clocks in last active line of frame
O_v_total  out  CNT_W  lines per frame
O_v_sync  out  CNT_W  lines started while VS active
O_v_active  out  CNT_W  lines containing >=1 DE clock
O_crc  out  16  CRC of lit-pixel bitstream for last frame
O_frame_cnt  out  16  completed frames measured
O_valid  out  1  one-cycle pulse when results update
O_locked  out  1  last two frames gave identical timing

Behaviour:
- Reset (async, I_rst=1): all outputs 0; internal counters 0; sync history regs = inactive level; first_frame flag set.
- Input sampling: hs/vs/de/rgb registered once (stage s1). Edges are computed from s1 versus previous s1 (s2).
- hs_edge = s1 HS active and s2 HS inactive. vs_edge is defined likewise.
- Line counters (all saturate at 2^CNT_W-1, never wrap):
  - hcnt: on hs_edge load 1, else +1.
  - hs_w: on hs_edge load 1, else +1 while HS active.
  - de_w: on hs_edge load 0, else +1 while DE.
- On each hs_edge, latch the line result of the line just ended:
  - line_total = hcnt; line_sync = hs_w.
  - If de_w != 0: last_active = de_w and vact +1.
  - vtot +1; vsync +1 if VS active in the edge cycle.
- Frame CRC: CRC-16-CCITT, poly 0x1021, MSB-first, 1 bit per DE cycle.
  - Bit = OR of all 24 RGB bits (s1). Non-DE cycles do not advance the CRC.
- Frame end = vs_edge:
  - If first_frame = 1: clear first_frame; reset frame accumulators (vtot, vsync, vact, last_active, crc = CRC_INIT); no output update, no O_valid.
  - Else: on the next cycle, load all O_* results atomically from the accumulators and the most recent line_total/line_sync.
  - Same update cycle: O_frame_cnt +1 (wraps 0xFFFF->0), O_valid = 1 for exactly one cycle.
  - Frame accumulators reset as in the first_frame case.
- Simultaneous hs_edge and vs_edge (normal VESA alignment): the line closes first and is counted in the ending frame. The new frame starts with counts at 0, and vtot/vsync of the new frame then include this starting line.
- O_locked:
  - Set in the update cycle if the new {h_total, h_sync, h_active, v_total, v_sync, v_active} equals the previous update's set.
  - Cleared on any mismatch.
  - First update after reset always clears it. CRC is not part of lock.
- Latency: O_valid is asserted 3 I_pxl_clk cycles after the VS active edge appears at the pins (s1, s2/edge, update).
- No HS for >2^CNT_W clocks: hcnt holds at max; reported O_h_total = max; O_locked drops at the next frame.
- DE held high across an hs_edge: the DE count splits at the edge; no error flag.

Test Plan:
- Drive 848x480 VESA timing (total 1088, sync 112, bporch 112; V total 517, sync 8, bporch 23), SYNC_POL=1, all-black, 3 frames. Required:
  - No O_valid after first VS edge.
  - Then O_h_total=1088, O_h_sync=112, O_h_active=848, O_v_total=517, O_v_sync=8, O_v_active=480, O_frame_cnt=1 then 2.
  - O_locked=0 after first update, 1 after second.
  - O_crc = CRC_INIT advanced by 407040 zero bits (golden from bench model).
- Same timing, single white pixel at DE index 0 of first active line: O_crc differs from the all-black golden and matches the model. Moving the pixel by 1 changes O_crc.
- Frame 3 shortens V total to 516 -> O_v_total=516, O_locked=0. Frame 4 at 516 again -> O_locked=1.
- Assert I_rst mid-frame (line 200) for 2 cycles -> all outputs 0 immediately (asynchronous). First following VS edge gives no O_valid; second gives valid 1088/517 results; O_frame_cnt=1.
- HS held inactive for 5000 clocks inside a frame -> O_h_total=4095 (saturated) at that frame's update, O_locked=0.
- SYNC_POL=0 with inverted sync waveforms -> results identical to the first scenario.
